// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding is fixed because state_o exposes it for debug.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PERF_W     = 32;
  localparam int CNT_W      = 3;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_LU_STALL = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_HALTED   = 3'd4
  } state_e;

  // Saturating increment for the event counters.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/pipe_load_use_det.sv
// Load-use hazard comparator: flags an IF/ID source that matches the
// destination of a load currently in ID/EX (x0 never hazards).
module pipe_load_use_det
  import pipe_ctrl_pkg::*;
(
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  hz
);

  always_comb begin
    hz = idex_memread && (idex_rd != '0) &&
         ((idex_rd == id_rs1) || (idex_rd == id_rs2));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables, flush strobes, load-use/memory stalls,
// redirects and halt/drain. Define PIPE_CTRL_PERF_EN to add event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYC = 1,
  parameter int DRAIN_CYC      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  exmem_redirect,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  input  logic                  halt_req,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  halt_ack,
`ifdef PIPE_CTRL_PERF_EN
  output logic [PERF_W-1:0]     perf_lu_stall,
  output logic [PERF_W-1:0]     perf_mem_wait,
  output logic [PERF_W-1:0]     perf_flush,
`endif
  output logic [2:0]            state_o
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LU_INIT    = CNT_W'((LOAD_STALL_CYC > 1) ? LOAD_STALL_CYC - 2 : 0);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYC - 1);

  state_e             state_q, state_d;
  state_e             ret_q, ret_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hz;
  logic               ev_bubble, ev_freeze, ev_flush;

  pipe_load_use_det u_lu_det (
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .hz           (hz)
  );

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latches).
    state_d      = state_q;
    ret_d        = ret_q;
    cnt_d        = cnt_q;
    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
    {if_id_flush, id_ex_flush, ex_mem_flush}          = '0;
    halt_ack     = 1'b0;
    ev_bubble    = 1'b0;
    ev_freeze    = 1'b0;
    ev_flush     = 1'b0;

    if (rst) begin
      // Outputs held low; the state registers reset on the clock edge.
    end else if (state_q == ST_HALTED) begin
      halt_ack = 1'b1;
      if (!halt_req) state_d = ST_RUN;
    end else if ((dmem_req && !dmem_ready) || (state_q == ST_MEM_WAIT && !dmem_ready)) begin
      ev_freeze = 1'b1;
      if (state_q != ST_MEM_WAIT) begin
        state_d = ST_MEM_WAIT;
        ret_d   = state_q;
      end
    end else if (exmem_redirect) begin
      ev_flush = 1'b1;
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
      {if_id_flush, id_ex_flush, ex_mem_flush}          = '1;
      // A drain in progress keeps counting down through a redirect.
      if (state_q == ST_DRAIN) begin
        if (cnt_q == '0) state_d = halt_req ? ST_HALTED : ST_RUN;
        else             cnt_d   = cnt_q - CNT_ONE;
      end else if (state_q == ST_MEM_WAIT && ret_q == ST_DRAIN) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_MEM_WAIT) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
      state_d = ret_q;
    end else if (state_q == ST_LU_STALL || (state_q == ST_RUN && hz)) begin
      ev_bubble   = 1'b1;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if (state_q == ST_RUN) begin
        if (LOAD_STALL_CYC > 1) begin
          state_d = ST_LU_STALL;
          cnt_d   = LU_INIT;
        end
      end else if (cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (state_q == ST_DRAIN) begin
      {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
      if_id_flush = 1'b1;
      if (cnt_q == '0) state_d = halt_req ? ST_HALTED : ST_RUN;
      else             cnt_d   = cnt_q - CNT_ONE;
    end else begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
      if (halt_req) begin
        state_d = ST_DRAIN;
        cnt_d   = DRAIN_INIT;
      end
    end
  end

  always_comb begin
    state_o = rst ? 3'd0 : state_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_lu_q, perf_lu_d;
  logic [PERF_W-1:0] perf_mw_q, perf_mw_d;
  logic [PERF_W-1:0] perf_fl_q, perf_fl_d;

  always_comb begin
    perf_lu_d = ev_bubble ? sat_inc(perf_lu_q) : perf_lu_q;
    perf_mw_d = ev_freeze ? sat_inc(perf_mw_q) : perf_mw_q;
    perf_fl_d = ev_flush  ? sat_inc(perf_fl_q) : perf_fl_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_q <= '0;
      perf_mw_q <= '0;
      perf_fl_q <= '0;
    end else begin
      perf_lu_q <= perf_lu_d;
      perf_mw_q <= perf_mw_d;
      perf_fl_q <= perf_fl_d;
    end
  end

  always_comb begin
    perf_lu_stall = rst ? '0 : perf_lu_q;
    perf_mem_wait = rst ? '0 : perf_mw_q;
    perf_flush    = rst ? '0 : perf_fl_q;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (LOAD_STALL_CYC=1 and 3,
// DRAIN_CYC=4) share stimulus; outputs are sampled 1 ns after each falling edge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       redir;
    logic       dreq;
    logic       drdy;
    logic       halt;
  } vec_t;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, ex_mem_fl, halt_ack}
  localparam logic [8:0] NRM = 9'b11111_000_0;
  localparam logic [8:0] BUB = 9'b00111_010_0;
  localparam logic [8:0] FRZ = 9'b00000_000_0;
  localparam logic [8:0] RDR = 9'b11111_111_0;
  localparam logic [8:0] DRN = 9'b01111_100_0;
  localparam logic [8:0] HLT = 9'b00000_000_1;

  logic clk = 1'b0;
  logic rst, idex_memread, exmem_redirect, dmem_req, dmem_ready, halt_req;
  logic [4:0] id_rs1, id_rs2, idex_rd;

  logic pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a;
  logic if_id_fl_a, id_ex_fl_a, ex_mem_fl_a, halt_ack_a;
  logic pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b;
  logic if_id_fl_b, id_ex_fl_b, ex_mem_fl_b, halt_ack_b;
  logic [2:0] st_a, st_b;
  logic [8:0] ctl_a, ctl_b;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] plu_a, pmw_a, pfl_a, plu_b, pmw_b, pfl_b;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign ctl_a = {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a,
                  if_id_fl_a, id_ex_fl_a, ex_mem_fl_a, halt_ack_a};
  assign ctl_b = {pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, mem_wb_en_b,
                  if_id_fl_b, id_ex_fl_b, ex_mem_fl_b, halt_ack_b};

  pipe_hazard_ctrl #(.LOAD_STALL_CYC(1), .DRAIN_CYC(4)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .exmem_redirect(exmem_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .pc_en(pc_en_a), .if_id_en(if_id_en_a), .id_ex_en(id_ex_en_a),
    .ex_mem_en(ex_mem_en_a), .mem_wb_en(mem_wb_en_a), .if_id_flush(if_id_fl_a),
    .id_ex_flush(id_ex_fl_a), .ex_mem_flush(ex_mem_fl_a), .halt_ack(halt_ack_a),
`ifdef PIPE_CTRL_PERF_EN
    .perf_lu_stall(plu_a), .perf_mem_wait(pmw_a), .perf_flush(pfl_a),
`endif
    .state_o(st_a)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYC(3), .DRAIN_CYC(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .exmem_redirect(exmem_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .pc_en(pc_en_b), .if_id_en(if_id_en_b), .id_ex_en(id_ex_en_b),
    .ex_mem_en(ex_mem_en_b), .mem_wb_en(mem_wb_en_b), .if_id_flush(if_id_fl_b),
    .id_ex_flush(id_ex_fl_b), .ex_mem_flush(ex_mem_fl_b), .halt_ack(halt_ack_b),
`ifdef PIPE_CTRL_PERF_EN
    .perf_lu_stall(plu_b), .perf_mem_wait(pmw_b), .perf_flush(pfl_b),
`endif
    .state_o(st_b)
  );

  function automatic vec_t mk(input logic r, input logic mr, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic redir,
                              input logic dreq, input logic drdy, input logic halt);
    return '{rst: r, mr: mr, rd: rd, rs1: rs1, rs2: rs2, redir: redir,
             dreq: dreq, drdy: drdy, halt: halt};
  endfunction

  function automatic logic [11:0] ex(input logic [8:0] c, input logic [2:0] s);
    return {c, s};
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; idex_memread = v.mr; idex_rd = v.rd; id_rs1 = v.rs1; id_rs2 = v.rs2;
    exmem_redirect = v.redir; dmem_req = v.dreq; dmem_ready = v.drdy; halt_req = v.halt;
    #1;
  endtask

  task automatic test_reset();
    vec_t v [3];
    logic [11:0] e [3];
    v[0] = mk(1, 1, 5'd5, 5'd5, 5'd0, 1, 1, 0, 1); e[0] = ex(9'd0, 3'd0);
    v[1] = mk(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0); e[1] = ex(9'd0, 3'd0);
    v[2] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); e[2] = ex(NRM, 3'd0);
    for (int i = 0; i < 3; i++) begin
      apply(v[i]);
      compared += 2;
      if ({ctl_a, st_a} !== e[i]) begin
        $display("FAIL reset_a[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_a, st_a, e[i][11:3], e[i][2:0]);
        mismatched++;
      end
      if ({ctl_b, st_b} !== e[i]) begin
        $display("FAIL reset_b[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_b, st_b, e[i][11:3], e[i][2:0]);
        mismatched++;
      end
    end
  endtask

  task automatic test_load_use();
    vec_t v [10];
    logic [11:0] ea [10], eb [10];
    v[0] = mk(0, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0, 0); ea[0] = ex(BUB, 0); eb[0] = ex(BUB, 0);
    v[1] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); ea[1] = ex(NRM, 0); eb[1] = ex(BUB, 1);
    v[2] = v[1];                                   ea[2] = ex(NRM, 0); eb[2] = ex(BUB, 1);
    v[3] = v[1];                                   ea[3] = ex(NRM, 0); eb[3] = ex(NRM, 0);
    v[4] = mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); ea[4] = ex(NRM, 0); eb[4] = ex(NRM, 0);
    v[5] = mk(0, 0, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0); ea[5] = ex(NRM, 0); eb[5] = ex(NRM, 0);
    v[6] = mk(0, 1, 5'd7, 5'd7, 5'd2, 0, 0, 0, 0); ea[6] = ex(BUB, 0); eb[6] = ex(BUB, 0);
    v[7] = v[1];                                   ea[7] = ex(NRM, 0); eb[7] = ex(BUB, 1);
    v[8] = v[1];                                   ea[8] = ex(NRM, 0); eb[8] = ex(BUB, 1);
    v[9] = v[1];                                   ea[9] = ex(NRM, 0); eb[9] = ex(NRM, 0);
    for (int i = 0; i < 10; i++) begin
      apply(v[i]);
      compared += 2;
      if ({ctl_a, st_a} !== ea[i]) begin
        $display("FAIL load_use_a[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_a, st_a, ea[i][11:3], ea[i][2:0]);
        mismatched++;
      end
      if ({ctl_b, st_b} !== eb[i]) begin
        $display("FAIL load_use_b[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_b, st_b, eb[i][11:3], eb[i][2:0]);
        mismatched++;
      end
    end
  endtask

  task automatic test_mem_wait();
    vec_t v [9];
    logic [11:0] ea [9], eb [9];
    v[0] = mk(0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0, 0); ea[0] = ex(BUB, 0); eb[0] = ex(BUB, 0);
    v[1] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0); ea[1] = ex(FRZ, 0); eb[1] = ex(FRZ, 1);
    v[2] = v[1];                                   ea[2] = ex(FRZ, 2); eb[2] = ex(FRZ, 2);
    v[3] = v[1];                                   ea[3] = ex(FRZ, 2); eb[3] = ex(FRZ, 2);
    v[4] = v[1];                                   ea[4] = ex(FRZ, 2); eb[4] = ex(FRZ, 2);
    v[5] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0); ea[5] = ex(NRM, 2); eb[5] = ex(NRM, 2);
    v[6] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); ea[6] = ex(NRM, 0); eb[6] = ex(BUB, 1);
    v[7] = v[6];                                   ea[7] = ex(NRM, 0); eb[7] = ex(BUB, 1);
    v[8] = v[6];                                   ea[8] = ex(NRM, 0); eb[8] = ex(NRM, 0);
    for (int i = 0; i < 9; i++) begin
      apply(v[i]);
      compared += 2;
      if ({ctl_a, st_a} !== ea[i]) begin
        $display("FAIL mem_wait_a[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_a, st_a, ea[i][11:3], ea[i][2:0]);
        mismatched++;
      end
      if ({ctl_b, st_b} !== eb[i]) begin
        $display("FAIL mem_wait_b[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_b, st_b, eb[i][11:3], eb[i][2:0]);
        mismatched++;
      end
    end
  endtask

  task automatic test_redirect();
    vec_t v [5];
    logic [11:0] ea [5], eb [5];
    v[0] = mk(0, 1, 5'd5, 5'd0, 5'd5, 1, 0, 0, 0); ea[0] = ex(RDR, 0); eb[0] = ex(RDR, 0);
    v[1] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); ea[1] = ex(NRM, 0); eb[1] = ex(NRM, 0);
    v[2] = mk(0, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0, 0); ea[2] = ex(BUB, 0); eb[2] = ex(BUB, 0);
    v[3] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0); ea[3] = ex(RDR, 0); eb[3] = ex(RDR, 1);
    v[4] = v[1];                                   ea[4] = ex(NRM, 0); eb[4] = ex(NRM, 0);
    for (int i = 0; i < 5; i++) begin
      apply(v[i]);
      compared += 2;
      if ({ctl_a, st_a} !== ea[i]) begin
        $display("FAIL redirect_a[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_a, st_a, ea[i][11:3], ea[i][2:0]);
        mismatched++;
      end
      if ({ctl_b, st_b} !== eb[i]) begin
        $display("FAIL redirect_b[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_b, st_b, eb[i][11:3], eb[i][2:0]);
        mismatched++;
      end
    end
  endtask

  task automatic test_halt();
    vec_t v [9];
    logic [11:0] e [9];
    v[0] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1); e[0] = ex(NRM, 0);
    for (int i = 1; i <= 4; i++) begin v[i] = v[0]; e[i] = ex(DRN, 3); end
    v[5] = v[0];                                   e[5] = ex(HLT, 4);
    v[6] = v[0];                                   e[6] = ex(HLT, 4);
    v[7] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); e[7] = ex(HLT, 4);
    v[8] = v[7];                                   e[8] = ex(NRM, 0);
    for (int i = 0; i < 9; i++) begin
      apply(v[i]);
      compared += 2;
      if ({ctl_a, st_a} !== e[i]) begin
        $display("FAIL halt_a[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_a, st_a, e[i][11:3], e[i][2:0]);
        mismatched++;
      end
      if ({ctl_b, st_b} !== e[i]) begin
        $display("FAIL halt_b[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_b, st_b, e[i][11:3], e[i][2:0]);
        mismatched++;
      end
    end
  endtask

  task automatic test_drain_release();
    vec_t v [6];
    logic [11:0] e [6];
    v[0] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1); e[0] = ex(NRM, 0);
    v[1] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0); e[1] = ex(RDR, 3);
    v[2] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); e[2] = ex(DRN, 3);
    v[3] = v[2];                                   e[3] = ex(DRN, 3);
    v[4] = v[2];                                   e[4] = ex(DRN, 3);
    v[5] = v[2];                                   e[5] = ex(NRM, 0);
    for (int i = 0; i < 6; i++) begin
      apply(v[i]);
      compared += 2;
      if ({ctl_a, st_a} !== e[i]) begin
        $display("FAIL drain_release_a[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_a, st_a, e[i][11:3], e[i][2:0]);
        mismatched++;
      end
      if ({ctl_b, st_b} !== e[i]) begin
        $display("FAIL drain_release_b[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_b, st_b, e[i][11:3], e[i][2:0]);
        mismatched++;
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    vec_t v [6];
    logic [11:0] e [6];
    v[0] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1); e[0] = ex(NRM, 0);
    v[1] = v[0];                                   e[1] = ex(DRN, 3);
    v[2] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1); e[2] = ex(9'd0, 0);
    v[3] = v[2];                                   e[3] = ex(9'd0, 0);
    v[4] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); e[4] = ex(NRM, 0);
    v[5] = v[4];                                   e[5] = ex(NRM, 0);
    for (int i = 0; i < 6; i++) begin
      apply(v[i]);
      compared += 2;
      if ({ctl_a, st_a} !== e[i]) begin
        $display("FAIL reset_drain_a[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_a, st_a, e[i][11:3], e[i][2:0]);
        mismatched++;
      end
      if ({ctl_b, st_b} !== e[i]) begin
        $display("FAIL reset_drain_b[%0d]: got ctl=%b st=%0d, want ctl=%b st=%0d", i, ctl_b, st_b, e[i][11:3], e[i][2:0]);
        mismatched++;
      end
`ifdef PIPE_CTRL_PERF_EN
      if (i == 1) begin
        compared++;
        if ({plu_a, pmw_a, pfl_a, plu_b, pmw_b, pfl_b} !== {32'd4, 32'd4, 32'd3, 32'd10, 32'd4, 32'd3}) begin
          $display("FAIL perf_counts: got a=%0d/%0d/%0d b=%0d/%0d/%0d, want a=4/4/3 b=10/4/3",
                   plu_a, pmw_a, pfl_a, plu_b, pmw_b, pfl_b);
          mismatched++;
        end
      end
      if (i == 4) begin
        compared++;
        if ({plu_a, pmw_a, pfl_a, plu_b, pmw_b, pfl_b} !== '0) begin
          $display("FAIL perf_cleared: got a=%0d/%0d/%0d b=%0d/%0d/%0d, want all 0",
                   plu_a, pmw_a, pfl_a, plu_b, pmw_b, pfl_b);
          mismatched++;
        end
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; idex_memread = 1'b0; idex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    exmem_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_redirect();
    test_halt();
    test_drain_release();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
